// File: rtl/reg_scoreboard_pkg.sv
// Shared types and constants for the decode-stage register scoreboard.
package reg_scoreboard_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int DEPTH    = 3;

  localparam logic [ADDR_W-1:0] LINK_REG = 3'd7;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } sb_state_t;

  typedef struct packed {
    logic              v;
    logic [ADDR_W-1:0] addr;
  } sb_entry_t;

  function automatic logic entry_match(input sb_entry_t e, input logic [ADDR_W-1:0] r);
    return e.v && (e.addr == r);
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode <-> scoreboard signal bundle; master is the decode side, slave the scoreboard.
interface reg_scoreboard_if #(
  parameter int CNT_W = 16
);
  import reg_scoreboard_pkg::*;

  logic              id_valid;
  logic              id_wr_en;
  logic [ADDR_W-1:0] id_wr_reg;
  logic [ADDR_W-1:0] id_rs_reg;
  logic              id_rs_used;
  logic [ADDR_W-1:0] id_rt_reg;
  logic              id_rt_used;
  logic              id_halt;
  logic              ex_flush;
  logic              mem_hold;

  logic              issue;
  logic              stall;
  logic              wb_reg_en;
  logic [ADDR_W-1:0] wb_reg_sel;
  logic              busy;
  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_wr_en, id_wr_reg, id_rs_reg, id_rs_used,
           id_rt_reg, id_rt_used, id_halt, ex_flush, mem_hold,
    input  issue, stall, wb_reg_en, wb_reg_sel, busy, halted, stall_cnt
  );

  modport slave (
    input  id_valid, id_wr_en, id_wr_reg, id_rs_reg, id_rs_used,
           id_rt_reg, id_rt_used, id_halt, ex_flush, mem_hold,
    output issue, stall, wb_reg_en, wb_reg_sel, busy, halted, stall_cnt
  );

endinterface

// File: rtl/reg_scoreboard_hazard_cmp.sv
// RAW hazard check of one decode source against the EX and MEM entries.
// A WB-stage match is deliberately ignored: the RF write-before-read covers it.
module sb_hazard_cmp
  import reg_scoreboard_pkg::*;
(
  input  logic [ADDR_W-1:0] src,
  input  logic              used,
  input  sb_entry_t         s0,
  input  sb_entry_t         s1,
  output logic              hit
);

  assign hit = used & (entry_match(s0, src) | entry_match(s1, src));

endmodule

// File: rtl/reg_scoreboard.sv
// Issue/writeback scheduler: tracks in-flight destinations, stalls decode on
// uncovered RAW hazards, times the RF write port and sequences halt drain.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  reg_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sb_state_t        state_q, state_d;
  sb_entry_t        stage_q [DEPTH];
  sb_entry_t        stage_d [DEPTH];
  logic             pend_flush_q, pend_flush_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic hit_rs, hit_rt;
  logic run, flush_now, stall, issue, busy;

  sb_hazard_cmp u_cmp_rs (
    .src  (bus.id_rs_reg),
    .used (bus.id_rs_used),
    .s0   (stage_q[0]),
    .s1   (stage_q[1]),
    .hit  (hit_rs)
  );

  sb_hazard_cmp u_cmp_rt (
    .src  (bus.id_rt_reg),
    .used (bus.id_rt_used),
    .s0   (stage_q[0]),
    .s1   (stage_q[1]),
    .hit  (hit_rt)
  );

  always_comb begin
    run       = (state_q == RUN);
    flush_now = bus.ex_flush | pend_flush_q;
    stall     = bus.id_valid & run & (hit_rs | hit_rt);
    issue     = bus.id_valid & run & ~stall & ~bus.mem_hold & ~flush_now;
    busy      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy = busy | stage_q[i].v;
    end
  end

  // A flush seen during a memory hold is remembered and applied on release.
  always_comb begin
    stage_d      = stage_q;
    pend_flush_d = 1'b0;
    if (bus.mem_hold) begin
      pend_flush_d = pend_flush_q | bus.ex_flush;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        stage_d[i] = stage_q[i-1];
      end
      stage_d[0].v    = issue & bus.id_wr_en;
      stage_d[0].addr = bus.id_wr_reg;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (issue && bus.id_halt) state_d = DRAIN;
      DRAIN:   if (!busy) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RUN;
      stage_q      <= '{default: '0};
      pend_flush_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      pend_flush_q <= pend_flush_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.issue      = issue;
  assign bus.stall      = stall;
  assign bus.wb_reg_en  = stage_q[DEPTH-1].v & ~bus.mem_hold;
  assign bus.wb_reg_sel = stage_q[DEPTH-1].addr;
  assign bus.busy       = busy;
  assign bus.halted     = (state_q == HALTED);
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: stimulus pushes expected RF writes,
// a negedge monitor pops and compares them whenever wb_reg_en is seen.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam int CNT_W = 4;

  typedef struct {
    logic [ADDR_W-1:0] r;
    int                cyc;
  } exp_wr_t;

  logic    clk = 1'b0;
  logic    rst;
  int      cyc = 0;
  int      n_checks = 0;
  int      n_fail = 0;
  exp_wr_t sb_q[$];

  reg_scoreboard_if #(.CNT_W(CNT_W)) bus ();

  reg_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One decode cycle: drive after the edge, check issue/stall mid-cycle,
  // and queue the expected RF write wb_delay cycles later if it should issue.
  task automatic applyStimulus(
    input logic v, input logic wr, input logic [ADDR_W-1:0] wreg,
    input logic [ADDR_W-1:0] rs, input logic rsu,
    input logic [ADDR_W-1:0] rt, input logic rtu,
    input logic halt, input logic flush, input logic hold,
    input logic exp_issue, input logic exp_stall, input int wb_delay,
    input string tag);
    exp_wr_t e;
    @(posedge clk);
    #1;
    bus.id_valid   = v;
    bus.id_wr_en   = wr;
    bus.id_wr_reg  = wreg;
    bus.id_rs_reg  = rs;
    bus.id_rs_used = rsu;
    bus.id_rt_reg  = rt;
    bus.id_rt_used = rtu;
    bus.id_halt    = halt;
    bus.ex_flush   = flush;
    bus.mem_hold   = hold;
    @(negedge clk);
    checkOutput({tag, ".issue"}, {31'd0, bus.issue}, {31'd0, exp_issue});
    checkOutput({tag, ".stall"}, {31'd0, bus.stall}, {31'd0, exp_stall});
    if (exp_issue && wr) begin
      e.r   = wreg;
      e.cyc = cyc + wb_delay;
      sb_q.push_back(e);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, "idle");
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_wr_t e;
    if (cyc > 0 && bus.wb_reg_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL wb_unexpected: got write to r%0d, expected no write (cycle %0d)",
                 bus.wb_reg_sel, cyc);
      end else begin
        e = sb_q.pop_front();
        checkOutput("wb.sel", {29'd0, bus.wb_reg_sel}, {29'd0, e.r});
        checkOutput("wb.cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst            = 1'b0;
    bus.id_valid   = 1'b0;
    bus.id_wr_en   = 1'b0;
    bus.id_wr_reg  = '0;
    bus.id_rs_reg  = '0;
    bus.id_rs_used = 1'b0;
    bus.id_rt_reg  = '0;
    bus.id_rt_used = 1'b0;
    bus.id_halt    = 1'b0;
    bus.ex_flush   = 1'b0;
    bus.mem_hold   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.busy", {31'd0, bus.busy}, 0);
    checkOutput("reset.wb_en", {31'd0, bus.wb_reg_en}, 0);
    checkOutput("reset.halted", {31'd0, bus.halted}, 0);
    checkOutput("reset.stall_cnt", {28'd0, bus.stall_cnt}, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Back-to-back RAW on r3 through rs: two stall cycles, write 3 clk after issue
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, "raw.prod");
    applyStimulus(1, 1, 4, 3, 1, 1, 0, 0, 0, 0, 0, 1, 3, "raw.s0");
    applyStimulus(1, 1, 4, 3, 1, 1, 0, 0, 0, 0, 0, 1, 3, "raw.s1");
    applyStimulus(1, 1, 4, 3, 1, 1, 0, 0, 0, 0, 1, 0, 3, "raw.s2");
    checkOutput("raw.wb_en", {31'd0, bus.wb_reg_en}, 1);
    checkOutput("raw.wb_sel", {29'd0, bus.wb_reg_sel}, 3);
    checkOutput("raw.stall_cnt", {28'd0, bus.stall_cnt}, 2);
    idleCycles(4);
    checkOutput("raw.busy_after", {31'd0, bus.busy}, 0);

    // Producer in WB stage: no stall, RF written the same cycle
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, "wb.prod");
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, "wb.f1");
    applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, "wb.f2");
    applyStimulus(1, 1, 6, 5, 1, 5, 1, 0, 0, 0, 1, 0, 3, "wb.cons");
    checkOutput("wb.wb_en", {31'd0, bus.wb_reg_en}, 1);
    checkOutput("wb.wb_sel", {29'd0, bus.wb_reg_sel}, 5);
    idleCycles(4);
    checkOutput("wb.busy_after", {31'd0, bus.busy}, 0);

    // Memory hold with a flush pulse: pipe frozen 3 cycles, one squash on release
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6, "hf.p1");
    applyStimulus(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6, "hf.p2");
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 6, "hf.p3");
    applyStimulus(1, 1, 4, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3, "hf.h1");
    checkOutput("hf.h1.wb_en", {31'd0, bus.wb_reg_en}, 0);
    checkOutput("hf.h1.busy", {31'd0, bus.busy}, 1);
    applyStimulus(1, 1, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, "hf.h2");
    checkOutput("hf.h2.wb_en", {31'd0, bus.wb_reg_en}, 0);
    applyStimulus(1, 1, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, "hf.h3");
    checkOutput("hf.h3.wb_en", {31'd0, bus.wb_reg_en}, 0);
    applyStimulus(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, "hf.squash");
    checkOutput("hf.release.wb_en", {31'd0, bus.wb_reg_en}, 1);
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, "hf.resume");
    idleCycles(4);
    checkOutput("hf.busy_after", {31'd0, bus.busy}, 0);

    // Counter saturation: r3 frozen in EX under hold while rt keeps stalling
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 23, "sat.prod");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 0, 1, 0, 3, 1, 0, 0, 1, 0, 1, 3, "sat.hold");
      checkOutput("sat.cnt", {28'd0, bus.stall_cnt}, (2 + i > 15) ? 15 : 2 + i);
    end
    applyStimulus(1, 0, 0, 1, 0, 3, 1, 0, 0, 0, 0, 1, 3, "sat.rel0");
    applyStimulus(1, 0, 0, 1, 0, 3, 1, 0, 0, 0, 0, 1, 3, "sat.rel1");
    applyStimulus(1, 0, 0, 1, 0, 3, 1, 0, 0, 0, 1, 0, 3, "sat.issue");
    checkOutput("sat.cnt_final", {28'd0, bus.stall_cnt}, 15);
    idleCycles(1);
    checkOutput("sat.busy_after", {31'd0, bus.busy}, 0);

    // Halt drain: JAL writes the link reg, HALT drains, later decode ignored
    applyStimulus(1, 1, LINK_REG, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, "halt.jal");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 3, "halt.halt");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 1, 2, LINK_REG, 1, 0, 0, 0, 0, 0, 0, 0, 3, "halt.drain");
      checkOutput("halt.halted", {31'd0, bus.halted}, (k >= 3) ? 1 : 0);
      checkOutput("halt.busy", {31'd0, bus.busy}, (k < 2) ? 1 : 0);
    end
    checkOutput("halt.cnt_frozen", {28'd0, bus.stall_cnt}, 15);

    // Reset mid-flight: leave HALTED, build 3 live entries and 2 stalls, then reset
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.id_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, "rst.p1");
    checkOutput("rst.halted_clr", {31'd0, bus.halted}, 0);
    applyStimulus(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 3, "rst.s0");
    applyStimulus(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 3, "rst.s1");
    applyStimulus(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 3, "rst.p2");
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, "rst.p3");
    applyStimulus(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, "rst.p4");
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.id_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst.pre_busy", {31'd0, bus.busy}, 1);
    checkOutput("rst.pre_cnt", {28'd0, bus.stall_cnt}, 2);
    @(posedge clk);
    #1;
    sb_q.delete();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst.busy", {31'd0, bus.busy}, 0);
    checkOutput("rst.wb_en", {31'd0, bus.wb_reg_en}, 0);
    checkOutput("rst.stall_cnt", {28'd0, bus.stall_cnt}, 0);

    idleCycles(3);
    checkOutput("final.queue_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
